// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: load-use/branch/HI-LO stalls, EX and ID forwarding,
// branch flush, mul/div busy counter and saturating stall/flush counters.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   id_*                : sources and class of the instruction in ID
//   branch_taken        : ID branch/jump resolves taken this cycle
//   ex_*                : ID/EX sources, destination, write/load/mul-div start
//   mem_*, wb_*         : EX/MEM and MEM/WB destinations and write/load flags
//   pc_stall,
//   if_id_stall,
//   id_ex_bubble        : all high while any stall condition holds
//   if_id_flush         : taken branch with operands ready
//   fwd_a, fwd_b        : EX operand select (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   fwd_id_a, fwd_id_b  : ID comparator operand from EX/MEM
//   muldiv_busy         : mul/div unit still computing
//   stall_cycles,
//   flush_cycles        : saturating event counters
module hazard_unit_mc #(
    parameter int REG_ADDR_W    = 5,
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_is_branch,
    input  logic                  id_uses_hilo,
    input  logic                  branch_taken,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_muldiv_start,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  fwd_id_a,
    output logic                  fwd_id_b,
    output logic                  muldiv_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
);

    localparam int MD_W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES);

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [REG_ADDR_W-1:0] a,
                                 input logic [REG_ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    logic [MD_W-1:0] md_cnt;
    logic            ex_hits_id;
    logic            mem_hits_id;
    logic            load_use;
    logic            br_haz;
    logic            hilo_haz;
    logic            stall;
    logic            mem_fwd_ok;

    assign ex_hits_id  = (id_uses_rs && hit(ex_rd, id_rs)) ||
                         (id_uses_rt && hit(ex_rd, id_rt));
    assign mem_hits_id = (id_uses_rs && hit(mem_rd, id_rs)) ||
                         (id_uses_rt && hit(mem_rd, id_rt));

    assign load_use = ex_mem_read && ex_hits_id;
    // Branches compare in ID, so any EX producer or a load still in MEM
    // cannot supply the operand in time.
    assign br_haz   = id_is_branch &&
                      ((ex_reg_write && ex_hits_id) ||
                       (mem_mem_read && mem_hits_id));
    assign hilo_haz = id_uses_hilo && (muldiv_busy || ex_muldiv_start);
    assign stall    = load_use || br_haz || hilo_haz;

    assign pc_stall     = stall;
    assign if_id_stall  = stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = branch_taken && !stall;

    // Load data is not available in EX/MEM, only ALU results are.
    assign mem_fwd_ok = mem_reg_write && !mem_mem_read;

    always_comb begin
        fwd_a = 2'b00;
        if (mem_fwd_ok && hit(mem_rd, ex_rs))
            fwd_a = 2'b10;
        else if (wb_reg_write && hit(wb_rd, ex_rs))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (mem_fwd_ok && hit(mem_rd, ex_rt))
            fwd_b = 2'b10;
        else if (wb_reg_write && hit(wb_rd, ex_rt))
            fwd_b = 2'b01;
    end

    assign fwd_id_a = mem_fwd_ok && hit(mem_rd, id_rs);
    assign fwd_id_b = mem_fwd_ok && hit(mem_rd, id_rt);

    assign muldiv_busy = (md_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= '0;
        else if (ex_muldiv_start)
            md_cnt <= MD_LOAD;
        else if (md_cnt != '0)
            md_cnt <= md_cnt - MD_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (if_id_flush && (flush_cycles != '1))
                flush_cycles <= flush_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios with literal expectations
// plus randomized traffic compared against a behavioural model each cycle.
module tb_hazard_unit_mc;

    localparam int RW  = 5;
    localparam int MDC = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          id_uses_rs, id_uses_rt, id_is_branch, id_uses_hilo;
    logic          branch_taken, ex_reg_write, ex_mem_read, ex_muldiv_start;
    logic          mem_reg_write, mem_mem_read, wb_reg_write;
    logic          pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          fwd_id_a, fwd_id_b, muldiv_busy;
    logic [CW-1:0] stall_cycles, flush_cycles;

    int tests = 0;
    int fails = 0;

    // model state
    int m_busy_left = 0;
    int m_stalls    = 0;
    int m_flushes   = 0;

    hazard_unit_mc #(
        .REG_ADDR_W   (RW),
        .MULDIV_CYCLES(MDC),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_is_branch   (id_is_branch),
        .id_uses_hilo   (id_uses_hilo),
        .branch_taken   (branch_taken),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_muldiv_start(ex_muldiv_start),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .fwd_id_a       (fwd_id_a),
        .fwd_id_b       (fwd_id_b),
        .muldiv_busy    (muldiv_busy),
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // does producer register p feed consumer register c (reg 0 never does)
    function automatic bit feeds(input int p, input int c);
        return p != 0 && p == c;
    endfunction

    function automatic bit id_reads(input int p);
        return (id_uses_rs && feeds(p, int'(id_rs))) ||
               (id_uses_rt && feeds(p, int'(id_rt)));
    endfunction

    function automatic bit m_stall();
        bit lu, br, hl;
        lu = ex_mem_read && id_reads(int'(ex_rd));
        br = id_is_branch &&
             ((ex_reg_write && id_reads(int'(ex_rd))) ||
              (mem_mem_read && id_reads(int'(mem_rd))));
        hl = id_uses_hilo && (m_busy_left > 0 || ex_muldiv_start);
        return lu || br || hl;
    endfunction

    function automatic int m_fwd(input int src);
        if (mem_reg_write && !mem_mem_read && feeds(int'(mem_rd), src))
            return 2;
        if (wb_reg_write && feeds(int'(wb_rd), src))
            return 1;
        return 0;
    endfunction

    function automatic int m_fwd_id(input int src);
        return int'(mem_reg_write && !mem_mem_read &&
                    feeds(int'(mem_rd), src));
    endfunction

    task automatic check_all();
        bit s;
        if (reset) begin
            m_busy_left = 0;
            m_stalls    = 0;
            m_flushes   = 0;
        end
        s = m_stall();
        chk("pc_stall", int'(pc_stall), int'(s));
        chk("if_id_stall", int'(if_id_stall), int'(s));
        chk("id_ex_bubble", int'(id_ex_bubble), int'(s));
        chk("if_id_flush", int'(if_id_flush), int'(branch_taken && !s));
        chk("fwd_a", int'(fwd_a), m_fwd(int'(ex_rs)));
        chk("fwd_b", int'(fwd_b), m_fwd(int'(ex_rt)));
        chk("fwd_id_a", int'(fwd_id_a), m_fwd_id(int'(id_rs)));
        chk("fwd_id_b", int'(fwd_id_b), m_fwd_id(int'(id_rt)));
        chk("muldiv_busy", int'(muldiv_busy), int'(m_busy_left > 0));
        chk("stall_cycles", int'(stall_cycles), m_stalls);
        chk("flush_cycles", int'(flush_cycles), m_flushes);
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    // advance one clock; model state follows the same edge
    task automatic tick();
        bit s, f;
        s = m_stall();
        f = branch_taken && !s;
        @(posedge clk);
        if (reset) begin
            m_busy_left = 0;
            m_stalls    = 0;
            m_flushes   = 0;
        end else begin
            if (ex_muldiv_start)
                m_busy_left = MDC;
            else if (m_busy_left > 0)
                m_busy_left--;
            if (s)
                m_stalls = (m_stalls + 1 > SAT) ? SAT : m_stalls + 1;
            if (f)
                m_flushes = (m_flushes + 1 > SAT) ? SAT : m_flushes + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0;
        id_uses_hilo = 0; branch_taken = 0; ex_reg_write = 0;
        ex_mem_read = 0; ex_muldiv_start = 0; mem_reg_write = 0;
        mem_mem_read = 0; wb_reg_write = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(negedge clk);
        do_reset();
        settle();
        chk("rst_stall_cnt", int'(stall_cycles), 0);
        chk("rst_flush_cnt", int'(flush_cycles), 0);
        chk("rst_busy", int'(muldiv_busy), 0);

        // load-use then forwarding from WB
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 8;
        id_rs = 8; id_uses_rs = 1;
        settle();
        chk("lu_stall", int'(pc_stall), 1);
        chk("lu_bubble", int'(id_ex_bubble), 1);
        tick();
        idle();
        mem_rd = 8; mem_reg_write = 1; mem_mem_read = 1; ex_rs = 8;
        settle();
        chk("lu_no_mem_fwd", int'(fwd_a), 0);
        chk("lu_stall_cnt", int'(stall_cycles), 1);
        tick();
        idle();
        wb_rd = 8; wb_reg_write = 1; ex_rs = 8;
        settle();
        chk("lu_wb_fwd", int'(fwd_a), 1);
        tick();

        // forwarding priority and register 0
        idle();
        mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
        ex_rs = 3; ex_rt = 3;
        settle();
        chk("fwd_pri_a", int'(fwd_a), 2);
        chk("fwd_pri_b", int'(fwd_b), 2);
        mem_rd = 4;
        settle();
        chk("fwd_wb_a", int'(fwd_a), 1);
        chk("fwd_wb_b", int'(fwd_b), 1);
        ex_rs = 0; mem_rd = 0;
        settle();
        chk("fwd_r0", int'(fwd_a), 0);
        tick();

        // branch on load result: two stall cycles then one flush
        do_reset();
        id_is_branch = 1; id_rs = 5; id_uses_rs = 1; branch_taken = 1;
        ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
        settle();
        chk("br_stall1", int'(pc_stall), 1);
        chk("br_noflush1", int'(if_id_flush), 0);
        tick();
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 5; mem_reg_write = 1; mem_mem_read = 1;
        settle();
        chk("br_stall2", int'(pc_stall), 1);
        tick();
        mem_rd = 0; mem_reg_write = 0; mem_mem_read = 0;
        wb_rd = 5; wb_reg_write = 1;
        settle();
        chk("br_go", int'(pc_stall), 0);
        chk("br_flush", int'(if_id_flush), 1);
        tick();
        idle();
        settle();
        chk("br_flush_once", int'(if_id_flush), 0);
        chk("br_stall_cnt", int'(stall_cycles), 2);
        chk("br_flush_cnt", int'(flush_cycles), 1);

        // mult in EX, mflo in ID: 5 stall cycles, released in the 6th
        do_reset();
        id_uses_hilo = 1; ex_muldiv_start = 1;
        settle();
        chk("md_stall0", int'(pc_stall), 1);
        chk("md_busy0", int'(muldiv_busy), 0);
        tick();
        ex_muldiv_start = 0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk("md_stall_n", int'(pc_stall), 1);
            chk("md_busy_n", int'(muldiv_busy), 1);
            tick();
        end
        settle();
        chk("md_release", int'(pc_stall), 0);
        chk("md_idle", int'(muldiv_busy), 0);
        chk("md_stall_cnt", int'(stall_cycles), 5);

        // asynchronous reset while the count is 2
        do_reset();
        id_uses_hilo = 1; ex_muldiv_start = 1;
        settle();
        tick();
        ex_muldiv_start = 0;
        settle();
        tick();
        settle();
        tick();
        settle();
        chk("ar_pre_cnt", int'(stall_cycles), 3);
        #2;
        reset = 1'b1;
        settle();
        chk("ar_busy", int'(muldiv_busy), 0);
        chk("ar_stall_cnt", int'(stall_cycles), 0);
        chk("ar_flush_cnt", int'(flush_cycles), 0);
        @(negedge clk);
        do_reset();

        // stall counter saturation
        idle();
        ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1;
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            settle();
            tick();
        end
        settle();
        chk("sat_stall", int'(stall_cycles), SAT);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            id_rs = RW'($urandom_range(0, 3));
            id_rt = RW'($urandom_range(0, 3));
            ex_rs = RW'($urandom_range(0, 3));
            ex_rt = RW'($urandom_range(0, 3));
            ex_rd = RW'($urandom_range(0, 3));
            mem_rd = RW'($urandom_range(0, 3));
            wb_rd = RW'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom);
            id_uses_rt = 1'($urandom);
            id_is_branch = ($urandom_range(0, 3) == 0);
            id_uses_hilo = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 2) == 0);
            ex_reg_write = 1'($urandom);
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_muldiv_start = ($urandom_range(0, 7) == 0);
            mem_reg_write = 1'($urandom);
            mem_mem_read = ($urandom_range(0, 3) == 0);
            wb_reg_write = 1'($urandom);
            settle();
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
